// File: rtl/core2wb_pipelined.sv
// rtl/core2wb_pipelined.sv - Ibex req/gnt/rvalid to pipelined Wishbone B4 bridge
// Registered request stage plus an outstanding-transfer counter; responses pass through combinationally.
module core2wb_pipelined #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int SW = DW / 8,
  localparam int OFS = $clog2(SW),
  localparam int WAW = AW - OFS,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           core_req,
  output logic           core_gnt,
  input  logic [AW-1:0]  core_addr,
  input  logic           core_we,
  input  logic [SW-1:0]  core_be,
  input  logic [DW-1:0]  core_wdata,
  output logic           core_rvalid,
  output logic [DW-1:0]  core_rdata,
  output logic           core_err,
  output logic           wb_cyc,
  output logic           wb_stb,
  output logic [WAW-1:0] wb_adr,
  output logic [SW-1:0]  wb_sel,
  output logic           wb_we,
  output logic [DW-1:0]  wb_dat_o,
  input  logic [DW-1:0]  wb_dat_i,
  input  logic           wb_ack,
  input  logic           wb_err,
  input  logic           wb_stall
);

  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_OUTSTANDING);

  logic           stb_q;
  logic [WAW-1:0] adr_q;
  logic [SW-1:0]  sel_q;
  logic           we_q;
  logic [DW-1:0]  dat_q;
  logic [CW-1:0]  cnt_q;

  logic           issue;
  logic           resp;
  logic           accept;
  logic [CW:0]    committed;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^core_addr[OFS-1:0];

  // Same-cycle responses are not credited back, so the grant is conservative.
  assign committed = {1'b0, cnt_q} + {{CW{1'b0}}, stb_q};
  assign issue     = stb_q && !wb_stall;
  assign resp      = (wb_ack || wb_err) && (cnt_q != '0);
  assign core_gnt  = (!stb_q || !wb_stall) && (committed < MAX_C);
  assign accept    = core_req && core_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        stb_q <= 1'b1;
      end else if (issue) begin
        stb_q <= 1'b0;
      end
      if (issue && !resp) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (resp && !issue) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Payload only moves on a grant, which keeps it stable across wb_stall.
  always_ff @(posedge clk) begin
    if (accept) begin
      adr_q <= core_addr[AW-1:OFS];
      sel_q <= core_we ? core_be : '1;
      we_q  <= core_we;
      dat_q <= core_wdata;
    end
  end

  assign wb_stb      = stb_q;
  assign wb_cyc      = stb_q || (cnt_q != '0);
  assign wb_adr      = adr_q;
  assign wb_sel      = sel_q;
  assign wb_we       = we_q;
  assign wb_dat_o    = dat_q;

  assign core_rvalid = resp;
  assign core_err    = resp && wb_err;
  assign core_rdata  = wb_dat_i;

endmodule

// File: tb/tb_core2wb_pipelined.sv
// tb/tb_core2wb_pipelined.sv - self-checking bench for core2wb_pipelined
// Queue model: one queue for the request register, one for issued-but-unanswered transfers.
module tb_core2wb_pipelined;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;
  localparam int SW = DW / 8;
  localparam int WAW = AW - 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           core_req;
  logic           core_gnt;
  logic [AW-1:0]  core_addr;
  logic           core_we;
  logic [SW-1:0]  core_be;
  logic [DW-1:0]  core_wdata;
  logic           core_rvalid;
  logic [DW-1:0]  core_rdata;
  logic           core_err;
  logic           wb_cyc;
  logic           wb_stb;
  logic [WAW-1:0] wb_adr;
  logic [SW-1:0]  wb_sel;
  logic           wb_we;
  logic [DW-1:0]  wb_dat_o;
  logic [DW-1:0]  wb_dat_i;
  logic           wb_ack;
  logic           wb_err;
  logic           wb_stall;

  core2wb_pipelined #(.DW(DW), .AW(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_addr(core_addr),
    .core_we(core_we), .core_be(core_be), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_we(wb_we), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
  );

  typedef struct packed {
    logic [WAW-1:0] adr;
    logic [SW-1:0]  sel;
    logic           we;
    logic [DW-1:0]  dat;
  } xfer_t;

  xfer_t pend[$];
  xfer_t infl[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_gnt();
    return (pend.size() == 0 || !wb_stall) && (pend.size() + infl.size() < MO);
  endfunction

  function automatic bit m_resp();
    return (wb_ack || wb_err) && infl.size() > 0;
  endfunction

  // Compare every output against the model, away from the rising edge.
  task automatic look();
    bit rv;
    @(negedge clk);
    rv = m_resp();
    chk("gnt", core_gnt, m_gnt());
    chk("stb", wb_stb, pend.size() > 0);
    chk("cyc", wb_cyc, pend.size() > 0 || infl.size() > 0);
    chk("rvalid", core_rvalid, rv);
    chk("err", core_err, rv && wb_err);
    if (rv) chk("rdata", core_rdata, wb_dat_i);
    if (pend.size() > 0) begin
      chk("adr", wb_adr, pend[0].adr);
      chk("sel", wb_sel, pend[0].sel);
      chk("we", wb_we, pend[0].we);
      chk("dat_o", wb_dat_o, pend[0].dat);
    end
  endtask

  task automatic tick();
    bit iss, rsp, g;
    xfer_t x;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      infl.delete();
    end else begin
      iss = pend.size() > 0 && !wb_stall;
      rsp = m_resp();
      g   = m_gnt();
      if (rsp) void'(infl.pop_front());
      if (iss) infl.push_back(pend.pop_front());
      if (core_req && g) begin
        x.adr = core_addr[AW-1:2];
        x.sel = core_we ? core_be : {SW{1'b1}};
        x.we  = core_we;
        x.dat = core_wdata;
        pend.push_back(x);
      end
      if (infl.size() > MO) begin
        fails++;
        $display("FAIL model_bound: outstanding %0d exceeds %0d", infl.size(), MO);
      end
    end
    #1;
  endtask

  task automatic req(input logic r, input logic [AW-1:0] a, input logic w, input logic [SW-1:0] be, input logic [DW-1:0] d);
    core_req = r; core_addr = a; core_we = w; core_be = be; core_wdata = d;
  endtask

  task automatic slave(input logic ack, input logic err, input logic stall, input logic [DW-1:0] d);
    wb_ack = ack; wb_err = err; wb_stall = stall; wb_dat_i = d;
  endtask

  initial begin
    rst = 1'b1;
    req(1'b1, 32'h0000_0040, 1'b0, 4'h1, 32'h0);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    look();
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_stb", wb_stb, 1'b0);
    chk("rst_rvalid", core_rvalid, 1'b0);
    tick();

    // Single read
    rst = 1'b0;
    req(1'b1, 32'h0000_1008, 1'b0, 4'h3, 32'h1234_5678);
    look(); chk("rd_gnt", core_gnt, 1'b1); tick();
    req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    look();
    chk("rd_stb", wb_stb, 1'b1);
    chk("rd_adr", wb_adr, 30'h402);
    chk("rd_sel", wb_sel, 4'hF);
    tick();
    look(); chk("rd_wait", core_rvalid, 1'b0); tick();
    slave(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    look();
    chk("rd_rvalid", core_rvalid, 1'b1);
    chk("rd_rdata", core_rdata, 32'hDEAD_BEEF);
    tick();
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    look(); chk("rd_cyc_drop", wb_cyc, 1'b0); tick();

    // Back-to-back writes; third waits for the first ack
    req(1'b1, 32'h100, 1'b1, 4'h1, 32'hA0); look(); chk("b2b_gnt0", core_gnt, 1'b1); tick();
    req(1'b1, 32'h104, 1'b1, 4'h2, 32'hA1); look(); chk("b2b_gnt1", core_gnt, 1'b1); tick();
    req(1'b1, 32'h108, 1'b1, 4'h4, 32'hA2); look(); chk("b2b_gnt2", core_gnt, 1'b0); tick();
    slave(1'b1, 1'b0, 1'b0, 32'h11);
    look(); chk("b2b_full", core_gnt, 1'b0); chk("b2b_rv1", core_rvalid, 1'b1); tick();
    look(); chk("b2b_gnt3", core_gnt, 1'b1); tick();
    req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    slave(1'b0, 1'b0, 1'b0, 32'h0);
    look(); chk("b2b_stb3", wb_adr, 30'h42); tick();
    slave(1'b1, 1'b0, 1'b0, 32'h33); look(); chk("b2b_rv3", core_rvalid, 1'b1); tick();
    slave(1'b0, 1'b0, 1'b0, 32'h0); look(); tick();

    // Stall holds the request register
    req(1'b1, 32'h0000_2000, 1'b1, 4'hC, 32'hCAFE_F00D); look(); tick();
    req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    slave(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      look();
      chk("stall_stb", wb_stb, 1'b1);
      chk("stall_adr", wb_adr, 30'h800);
      chk("stall_dat", wb_dat_o, 32'hCAFE_F00D);
      chk("stall_gnt", core_gnt, 1'b0);
      tick();
    end
    slave(1'b0, 1'b0, 1'b0, 32'h0); look(); tick();
    look(); chk("stall_cyc", wb_cyc, 1'b1); chk("stall_stb_off", wb_stb, 1'b0); tick();
    slave(1'b1, 1'b0, 1'b0, 32'h5); look(); chk("stall_rv", core_rvalid, 1'b1); tick();
    slave(1'b0, 1'b0, 1'b0, 32'h0);

    // Issue and error together, then ack+err together, then a spurious ack
    req(1'b1, 32'h300, 1'b0, 4'h0, 32'h0); look(); tick();
    req(1'b1, 32'h304, 1'b0, 4'h0, 32'h0); look(); chk("err_gnt", core_gnt, 1'b1); tick();
    req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    slave(1'b0, 1'b1, 1'b0, 32'h0);
    look(); chk("err_rv", core_rvalid, 1'b1); chk("err_err", core_err, 1'b1); tick();
    slave(1'b0, 1'b0, 1'b0, 32'h0); look(); chk("err_cnt_kept", wb_cyc, 1'b1); tick();
    slave(1'b1, 1'b1, 1'b0, 32'h0);
    look(); chk("ackerr_rv", core_rvalid, 1'b1); chk("ackerr_err", core_err, 1'b1); tick();
    slave(1'b1, 1'b0, 1'b0, 32'h0);
    look(); chk("spur_rv", core_rvalid, 1'b0); chk("spur_cyc", wb_cyc, 1'b0); tick();
    slave(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset with two transfers outstanding
    req(1'b1, 32'h400, 1'b0, 4'h0, 32'h0); look(); tick();
    req(1'b1, 32'h404, 1'b0, 4'h0, 32'h0); look(); tick();
    req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0); look(); tick();
    rst = 1'b1; look(); tick();
    rst = 1'b0;
    look(); chk("mid_rst_cyc", wb_cyc, 1'b0); tick();
    slave(1'b1, 1'b0, 1'b0, 32'h0); look(); chk("mid_rst_ack", core_rvalid, 1'b0); tick();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      req($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1), SW'($urandom), $urandom);
      slave($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3, $urandom);
      look();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core2wb_pipelined.md
Name: core2wb_pipelined

Overview:
- Next-generation Ibex-core-to-Wishbone bridge: converts the core LSU/instruction request/grant/rvalid protocol into pipelined Wishbone B4 (cyc/stb/stall/ack/err).
- Unlike the single-transaction bridge, it supports up to MAX_OUTSTANDING in-flight transfers and registers the request stage, so throughput is one transfer per cycle.
- Sits between an Ibex core port (instr or data) and a Wishbone interconnect master port; data and address widths are parametrised.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8, power of two, >= 16.
- AW, 32, core byte-address width.
- MAX_OUTSTANDING, 2, max issued-but-unanswered WB transfers; range 1..16.
- Derived: SW = DW/8; OFS = log2(SW); WAW = AW-OFS; CW = clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- core_req  in  1  core request.
- core_gnt  out  1  request accepted this cycle when core_req && core_gnt.
- core_addr  in  AW  byte address.
- core_we  in  1  write enable.
- core_be  in  SW  byte enables.
- core_wdata  in  DW  write data.
- core_rvalid  out  1  response valid, one per granted request, in order.
- core_rdata  out  DW  read data, valid with core_rvalid.
- core_err  out  1  bus error, valid only with core_rvalid.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_adr  out  WAW  word address = core_addr[AW-1:OFS].
- wb_sel  out  SW  core_be if write, else all ones.
- wb_we  out  1  write enable.
- wb_dat_o  out  DW  write data.
- wb_dat_i  in  DW  read data.
- wb_ack  in  1  slave acknowledge.
- wb_err  in  1  slave error.
- wb_stall  in  1  slave stall.

Behaviour:
- Request register: stb_q, adr_q, sel_q, we_q, dat_q. outstanding counter cnt_q (CW bits).
- Reset (sync, rst=1 at posedge): stb_q=0, cnt_q=0. Outputs therefore wb_cyc=0, wb_stb=0, core_rvalid=0, core_err=0. Payload registers need no reset.
- Reset mid-operation clears everything; acks/errs arriving after reset with cnt_q=0 are ignored.
- issue = stb_q && !wb_stall.
- resp = (wb_ack || wb_err) && cnt_q != 0.
- core_gnt = (!stb_q || !wb_stall) && (cnt_q + stb_q < MAX_OUTSTANDING). Same-cycle responses are not credited, so the count is conservative.
- On core_req && core_gnt: load request register from core_* fields and set stb_q=1. Latency req -> wb_stb is 1 cycle.
- On issue with no new grant: stb_q<=0.
- While stalled: stb_q and the payload hold stable, per WB pipelined rules.
- Combinational outputs: wb_stb = stb_q; wb_cyc = stb_q || cnt_q != 0; wb_adr/sel/we/dat_o come from the request register.
- cnt_q update:
  - +1 on issue only.
  - -1 on resp only.
  - Unchanged on both or neither.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- Response path (combinational, zero latency):
  - core_rvalid = resp.
  - core_err = resp && wb_err.
  - core_rdata = wb_dat_i.
  - ack and err in the same cycle count as one error response.
  - Spurious ack/err with cnt_q=0: no rvalid, no count change.
- Errors do not abort later outstanding transfers; each still gets its own response.
- MAX_OUTSTANDING=1 degenerates to the classic one-at-a-time bridge, plus one cycle of request latency.
- wb_cyc drops in the cycle after the last response when no new request is pending.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with core_req=1 -> wb_cyc=0, wb_stb=0, core_gnt issue ignored; after release, first gnt=1 and wb_stb=1 the next cycle.
- Single read (DW=32): addr=0x0000_1008, we=0, be=0x3 -> wb_adr=0x402, wb_sel=0xF; slave acks 2 cycles later with dat_i=0xDEADBEEF -> core_rvalid=1 for one cycle with rdata=0xDEADBEEF; cnt returns to 0; wb_cyc low the next cycle.
- Back-to-back pipelined writes (MAX_OUTSTANDING=2, no stall): 3 requests on consecutive cycles -> gnt=1,1,0 (third held until the first ack); 3 in-order rvalids; cnt peaks at 2.
- Stall: wb_stall=1 for 3 cycles with a request in the register -> stb, adr, dat stable for all 3 cycles; gnt=0; one transfer issued on release; cnt increments exactly once.
- Error plus simultaneous events: issue and wb_err in the same cycle with cnt=1 -> core_rvalid=1, core_err=1, cnt stays 1. A separate cycle with wb_ack and wb_err both high -> one response, err=1.
- Spurious and mid-op reset: wb_ack with cnt=0 -> no rvalid. rst asserted with cnt=2 -> cnt=0, cyc=0; later acks are ignored.
